// File: rtl/music_pkg.sv
// Shared types and constants for the tone player and its millisecond prescaler.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int DUR_W_DEF  = 16;

  // Clock cycles per millisecond; never below one so the prescaler always ticks.
  function automatic int ms_ticks(input int clk_hz);
    int t;
    t = clk_hz / 1000;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS_TICKS-1 while enabled and flags the
// terminal count with a one-cycle tick. Shared by the PLAY and GAP timing.
module ms_tick_gen
  import music_pkg::*;
#(
  parameter int MS_TICKS = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  logic [31:0] ms_cnt;

  assign tick = en && (ms_cnt == 32'(MS_TICKS - 1));

  // Prescaler count: clear has priority, wrap to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ms_cnt <= '0;
    end else if (en) begin
      ms_cnt <= tick ? '0 : ms_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Square-wave note player. Accepts {half_period, dur_ms} on a valid/ready
// handshake, drives speaker for exactly dur_ms milliseconds, then pulses
// note_done. Optional articulation gap after each note: define ARTIC_GAP_EN.
//
// state | meaning
// IDLE  | waiting for a note; note_ready high
// PLAY  | tone running from the latched half-period for the latched duration
// GAP   | silent articulation gap (ARTIC_GAP_EN builds only)
module tone_player
  import music_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int MS_TICKS = ms_ticks(CLK_HZ),
  parameter int DUR_W    = DUR_W_DEF
`ifdef ARTIC_GAP_EN
  ,
  parameter int GAP_MS   = 20
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [31:0]      half_period,
  input  logic [DUR_W-1:0] dur_ms,
  output logic             speaker,
  output logic             busy,
  output logic             note_done
);

  state_t      state, state_nxt;
  logic [31:0] hp_lat, hp_lat_nxt;
  logic [31:0] hp_cnt, hp_cnt_nxt;
  logic [31:0] dur_left, dur_left_nxt;
  logic        speaker_nxt;
  logic        note_done_nxt;
  logic        ms_clear, ms_en, ms_tick;
`ifdef ARTIC_GAP_EN
  logic [31:0] gap_left, gap_left_nxt;
`endif

  assign note_ready = (state == IDLE);
  assign busy       = !note_ready;

  ms_tick_gen #(
    .MS_TICKS (MS_TICKS)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clear (ms_clear),
    .en    (ms_en),
    .tick  (ms_tick)
  );

  // Next-state and datapath: accept, tone toggling, duration and gap timing.
  always_comb begin
    state_nxt     = state;
    hp_lat_nxt    = hp_lat;
    hp_cnt_nxt    = hp_cnt;
    dur_left_nxt  = dur_left;
    speaker_nxt   = speaker;
    note_done_nxt = 1'b0;
    ms_clear      = 1'b0;
    ms_en         = 1'b0;
`ifdef ARTIC_GAP_EN
    gap_left_nxt  = gap_left;
`endif
    case (state)
      IDLE: begin
        if (note_valid) begin
          hp_lat_nxt   = half_period;
          dur_left_nxt = 32'(dur_ms);
          hp_cnt_nxt   = '0;
          ms_clear     = 1'b1;
          speaker_nxt  = 1'b0;
          // A zero-length note completes without ever leaving IDLE.
          if (dur_ms == '0) begin
            note_done_nxt = 1'b1;
          end else begin
            state_nxt = PLAY;
          end
        end
      end

      PLAY: begin
        ms_en = 1'b1;
        if (hp_lat == '0) begin
          speaker_nxt = 1'b0;
        end else if (hp_cnt == hp_lat - 32'd1) begin
          speaker_nxt = !speaker;
          hp_cnt_nxt  = '0;
        end else begin
          hp_cnt_nxt = hp_cnt + 32'd1;
        end

        if (ms_tick) begin
          if (dur_left == 32'd1) begin
            // Last cycle of the note: forced silence wins over any toggle.
            speaker_nxt   = 1'b0;
            note_done_nxt = 1'b1;
            dur_left_nxt  = '0;
            hp_cnt_nxt    = '0;
`ifdef ARTIC_GAP_EN
            if (GAP_MS == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt    = GAP;
              gap_left_nxt = 32'(GAP_MS);
              ms_clear     = 1'b1;
            end
`else
            state_nxt = IDLE;
`endif
          end else begin
            dur_left_nxt = dur_left - 32'd1;
          end
        end
      end

`ifdef ARTIC_GAP_EN
      GAP: begin
        ms_en       = 1'b1;
        speaker_nxt = 1'b0;
        if (ms_tick) begin
          if (gap_left <= 32'd1) begin
            gap_left_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            gap_left_nxt = gap_left - 32'd1;
          end
        end
      end
`endif

      default: begin
        state_nxt   = IDLE;
        speaker_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any note without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hp_lat    <= '0;
      hp_cnt    <= '0;
      dur_left  <= '0;
      speaker   <= 1'b0;
      note_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      hp_lat    <= hp_lat_nxt;
      hp_cnt    <= hp_cnt_nxt;
      dur_left  <= dur_left_nxt;
      speaker   <= speaker_nxt;
      note_done <= note_done_nxt;
    end
  end

`ifdef ARTIC_GAP_EN
  // Remaining gap milliseconds.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_left <= '0;
    end else begin
      gap_left <= gap_left_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tone_player.sv
// Testbench for tone_player with a shortened millisecond (MS_TICKS=10).
// Optional gap build: define ARTIC_GAP_EN (gap of 2 ms is used here).
module tb_tone_player;

  localparam int MS = 10;
`ifdef ARTIC_GAP_EN
  localparam int GAP_MS  = 2;
  localparam int GAP_CYC = GAP_MS * MS;
`else
  localparam int GAP_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        note_valid;
  logic        note_ready;
  logic [31:0] half_period;
  logic [15:0] dur_ms;
  logic        speaker;
  logic        busy;
  logic        note_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  tone_player #(
    .MS_TICKS (MS),
    .DUR_W    (16)
`ifdef ARTIC_GAP_EN
    ,
    .GAP_MS   (GAP_MS)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .half_period (half_period),
    .dur_ms      (dur_ms),
    .speaker     (speaker),
    .busy        (busy),
    .note_done   (note_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!note_ready && k < 100) begin
      step();
      k++;
    end
    if (!note_ready) check("wait_ready", note_ready, 1);
  endtask

  typedef struct {
    logic [31:0] hp;
    logic [15:0] dur;
    int          exp_tog;
    int          exp_done;
  } note_vec_t;

  note_vec_t vecs[8];

  // Higher-level reference: a note accepted at edge s with duration D*MS
  // silences at edge s+D*MS; in between the speaker level after edge n is the
  // parity of floor((n-s)/hp).
  longint m_n, m_start, m_done, m_idle_from;
  int     m_hp;
  bit     m_has;

  initial begin
    int tog, done_at;
    logic prev;
    int dones, loud;

    vecs[0] = '{hp: 32'd3,  dur: 16'd2, exp_tog: 6, exp_done: 20};
    vecs[1] = '{hp: 32'd0,  dur: 16'd3, exp_tog: 0, exp_done: 30};
    vecs[2] = '{hp: 32'd5,  dur: 16'd0, exp_tog: 0, exp_done: 0};
    vecs[3] = '{hp: 32'd1,  dur: 16'd1, exp_tog: 9, exp_done: 10};
    vecs[4] = '{hp: 32'd4,  dur: 16'd1, exp_tog: 2, exp_done: 10};
    vecs[5] = '{hp: 32'd7,  dur: 16'd3, exp_tog: 4, exp_done: 30};
    vecs[6] = '{hp: 32'd10, dur: 16'd1, exp_tog: 0, exp_done: 10};
    vecs[7] = '{hp: 32'd11, dur: 16'd1, exp_tog: 0, exp_done: 10};

    cyc = 0;
    reset = 1'b1;
    note_valid = 1'b0;
    half_period = '0;
    dur_ms = '0;
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_speaker", speaker, 0);
      check("idle_ready", note_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_done", note_done, 0);
    end

    // Single notes from IDLE.
    foreach (vecs[i]) begin
      wait_ready();
      half_period = vecs[i].hp;
      dur_ms = vecs[i].dur;
      note_valid = 1'b1;
      step();
      note_valid = 1'b0;
      half_period = 32'd2;
      dur_ms = 16'd7;
      check("accept_busy", busy, (vecs[i].dur != 0) ? 1 : 0);
      tog = 0;
      prev = 1'b0;
      done_at = -1;
      for (int c = 0; c <= 200; c++) begin
        if (c > 0) step();
        if (note_done === 1'b1) begin
          done_at = c;
          break;
        end
        if (speaker !== prev) tog++;
        prev = speaker;
      end
      check("note_done_cycle", done_at, vecs[i].exp_done);
      check("toggle_count", tog, vecs[i].exp_tog);
      check("speaker_at_done", speaker, 0);
      check("ready_at_done", note_ready, (vecs[i].dur == 0 || GAP_CYC == 0) ? 1 : 0);
      step();
      check("done_one_cycle", note_done, 0);
    end

    // Back-to-back notes with note_valid held high.
    wait_ready();
    half_period = 32'd2;
    dur_ms = 16'd1;
    note_valid = 1'b1;
    step();
    cyc = 0;
    half_period = 32'd4;
    while (cyc < 2) step();
    check("b2b_first_hp_latched", speaker, 1);
    while (cyc < 10) step();
    check("b2b_first_done", note_done, 1);
    check("b2b_ready_in_done", note_ready, (GAP_CYC == 0) ? 1 : 0);
    while (cyc < 11 + GAP_CYC) step();
    check("b2b_second_accepted", busy, 1);
    check("b2b_second_done_low", note_done, 0);
    note_valid = 1'b0;
    while (cyc < 15 + GAP_CYC) step();
    check("b2b_second_hp", speaker, 1);
    while (cyc < 20 + GAP_CYC) step();
    check("b2b_second_not_early", note_done, 0);
    step();
    check("b2b_second_done", note_done, 1);

    // Reset in the middle of a note.
    wait_ready();
    half_period = 32'd3;
    dur_ms = 16'd2;
    note_valid = 1'b1;
    step();
    cyc = 0;
    note_valid = 1'b0;
    while (cyc < 3) step();
    check("abort_pre_toggle", speaker, 1);
    while (cyc < 6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_speaker", speaker, 0);
    check("abort_ready", note_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", note_done, 0);
    dones = 0;
    loud = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (note_done === 1'b1) dones++;
      if (speaker !== 1'b0) loud++;
    end
    check("abort_no_done", dones, 0);
    check("abort_silent", loud, 0);

    // Randomized stimulus against the reference model.
    m_n = 0;
    m_has = 0;
    m_idle_from = 0;
    m_start = 0;
    m_done = 0;
    m_hp = 0;
    for (int it = 0; it < 3000; it++) begin
      logic r, v;
      logic [31:0] hp;
      logic [15:0] d;
      logic exp_spk, exp_rdy, exp_done;
      r = (it == 0) || ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) != 0);
      hp = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
      d = 16'($urandom_range(0, 3));
      reset = r;
      note_valid = v;
      half_period = hp;
      dur_ms = d;
      step();
      m_n++;
      if (r) begin
        m_has = 0;
        m_idle_from = m_n;
      end else if (v && (m_n - 1) >= m_idle_from) begin
        m_has = 1;
        m_start = m_n;
        m_hp = int'(hp);
        m_done = m_n + longint'(d) * MS;
        m_idle_from = (d == 0) ? m_n : m_done + GAP_CYC;
      end
      exp_rdy = (m_n >= m_idle_from);
      exp_done = m_has && (m_n == m_done);
      exp_spk = 1'b0;
      if (m_has && hp_nonzero(m_hp) && m_n > m_start && m_n < m_done)
        exp_spk = (((m_n - m_start) / longint'(unsigned'(m_hp))) % 2) == 1;
      check("rnd_speaker", speaker, exp_spk);
      check("rnd_ready", note_ready, exp_rdy);
      check("rnd_busy", busy, !exp_rdy);
      check("rnd_done", note_done, exp_done);
    end
    reset = 1'b0;
    note_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic bit hp_nonzero(input int hp);
    return hp != 0;
  endfunction

endmodule
